// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM mux/demux path.
//   state_t      : demux framing state (HUNT / LOCKED)
//   DEF_NUM_CH   : default number of slots per frame
//   DEF_DATA_W   : default sample width
//   clog2()      : ceiling log2, used to size slot counters on both ends
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DATA_W = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Modulo-NUM_CH slot counter shared by the TDM transmit and receive sides.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance one slot, wrapping to 0 after NUM_CH-1
//   load1      : force slot to 1 (the slot following a sync beat)
//   clr        : force slot to 0; priority clr > load1 > en
//   slot       : current slot index
//   last_slot  : slot == NUM_CH-1
module tdm_slot_ctr
  import tdm_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SLOT_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load1,
  input  logic              clr,
  output logic [SLOT_W-1:0] slot,
  output logic              last_slot
);

  // Explicit compare keeps non-power-of-2 NUM_CH legal.
  assign last_slot = (slot == SLOT_W'(NUM_CH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (clr) begin
      slot <= '0;
    end else if (load1) begin
      slot <= SLOT_W'(1);
    end else if (en) begin
      slot <= last_slot ? '0 : slot + 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux1x4.sv
// Time-division demultiplexer: splits one interleaved sample stream into
// NUM_CH channel registers, tracking frame alignment via frame_sync on slot 0.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   din         : interleaved sample
//   din_valid   : din carries a sample this cycle
//   frame_sync  : current sample is slot 0 (qualified by din_valid)
//   ch_data     : channel k at [k*DATA_W +: DATA_W], held until next write
//   ch_valid    : one-cycle pulse on the channel that was written
//   frame_done  : one-cycle pulse when the last slot is written while locked
//   locked      : framing is locked
//   sync_err    : one-cycle pulse on misplaced or missing sync while locked
//
// state  | meaning
// HUNT   | discard beats until one carries frame_sync
// LOCKED | route beats by slot; count frames with missing sync
module tdm_demux1x4
  import tdm_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MISS_LIMIT = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        din,
  input  logic                     din_valid,
  input  logic                     frame_sync,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_valid,
  output logic                     frame_done,
  output logic                     locked,
  output logic                     sync_err
);

  localparam int SLOT_W = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH);

  state_t            state, state_nxt;
  logic [3:0]        miss_cnt, miss_nxt, miss_inc;
  logic [SLOT_W-1:0] slot, wr_idx;
  logic              last_slot;
  logic              wr_en, ctr_en, ctr_load, ctr_clr;
  logic              err_nxt, done_nxt;
  logic [NUM_CH-1:0] valid_nxt;

  tdm_slot_ctr #(
    .NUM_CH (NUM_CH),
    .SLOT_W (SLOT_W)
  ) u_slot_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (ctr_en),
    .load1     (ctr_load),
    .clr       (ctr_clr),
    .slot      (slot),
    .last_slot (last_slot)
  );

  assign miss_inc = miss_cnt + 4'd1;
  assign locked   = (state == LOCKED);

  always_comb begin
    state_nxt = state;
    miss_nxt  = miss_cnt;
    wr_en     = 1'b0;
    wr_idx    = '0;
    ctr_en    = 1'b0;
    ctr_load  = 1'b0;
    ctr_clr   = 1'b0;
    err_nxt   = 1'b0;
    done_nxt  = 1'b0;
    if (din_valid) begin
      case (state)
        HUNT: begin
          if (frame_sync) begin
            wr_en     = 1'b1;
            ctr_load  = 1'b1;
            miss_nxt  = '0;
            state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_sync) begin
            // A sync anywhere restarts the frame; off-slot-0 is an error.
            err_nxt  = (slot != '0);
            wr_en    = 1'b1;
            ctr_load = 1'b1;
            miss_nxt = '0;
          end else if (slot == '0) begin
            err_nxt = 1'b1;
            if (miss_inc >= 4'(MISS_LIMIT)) begin
              state_nxt = HUNT;
              ctr_clr   = 1'b1;
              miss_nxt  = '0;
            end else begin
              // Flywheel: keep routing on the assumed frame timing.
              miss_nxt = miss_inc;
              wr_en    = 1'b1;
              ctr_en   = 1'b1;
            end
          end else begin
            wr_en    = 1'b1;
            wr_idx   = slot;
            ctr_en   = 1'b1;
            done_nxt = last_slot;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_comb begin
    valid_nxt = '0;
    if (wr_en) valid_nxt[wr_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      miss_cnt   <= '0;
      ch_data    <= '0;
      ch_valid   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      miss_cnt   <= miss_nxt;
      ch_valid   <= valid_nxt;
      frame_done <= done_nxt;
      sync_err   <= err_nxt;
      for (int k = 0; k < NUM_CH; k++) begin
        if (valid_nxt[k]) ch_data[k*DATA_W +: DATA_W] <= din;
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux1x4.sv
module tb_tdm_demux1x4;

  localparam int NUM_CH     = 4;
  localparam int DATA_W     = 8;
  localparam int MISS_LIMIT = 3;

  logic                     clk;
  logic                     rst_n;
  logic [DATA_W-1:0]        din;
  logic                     din_valid;
  logic                     frame_sync;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_valid;
  logic                     frame_done;
  logic                     locked;
  logic                     sync_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DATA_W-1:0] m_ch [NUM_CH];
  logic [NUM_CH-1:0] m_valid;
  logic              m_done;
  logic              m_err;
  logic              m_locked;
  int                m_slot;
  int                m_miss;

  tdm_demux1x4 #(
    .NUM_CH     (NUM_CH),
    .DATA_W     (DATA_W),
    .MISS_LIMIT (MISS_LIMIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .ch_data    (ch_data),
    .ch_valid   (ch_valid),
    .frame_done (frame_done),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) m_ch[k] = '0;
    m_valid = '0; m_done = 1'b0; m_err = 1'b0;
    m_locked = 1'b0; m_slot = 0; m_miss = 0;
  endtask

  task automatic model_write(input int idx, input logic [DATA_W-1:0] d);
    m_ch[idx] = d;
    m_valid = '0;
    m_valid[idx] = 1'b1;
  endtask

  task automatic model_step(input logic v, input logic s, input logic [DATA_W-1:0] d);
    m_valid = '0; m_done = 1'b0; m_err = 1'b0;
    if (!v) return;
    if (!m_locked) begin
      if (s) begin
        model_write(0, d); m_slot = 1; m_miss = 0; m_locked = 1'b1;
      end
    end else if (s) begin
      m_err = (m_slot != 0);
      model_write(0, d); m_slot = 1; m_miss = 0;
    end else if (m_slot == 0) begin
      m_err = 1'b1;
      m_miss++;
      if (m_miss >= MISS_LIMIT) begin
        m_locked = 1'b0; m_slot = 0; m_miss = 0;
      end else begin
        model_write(0, d); m_slot = 1;
      end
    end else begin
      model_write(m_slot, d);
      m_done = (m_slot == NUM_CH - 1);
      m_slot = (m_slot + 1) % NUM_CH;
    end
  endtask

  function automatic logic [NUM_CH*DATA_W-1:0] model_data();
    logic [NUM_CH*DATA_W-1:0] r;
    for (int k = 0; k < NUM_CH; k++) r[k*DATA_W +: DATA_W] = m_ch[k];
    return r;
  endfunction

  // Drives one cycle; returns 1 ns after the active edge with the model updated.
  task automatic drive(input logic v, input logic s, input logic [DATA_W-1:0] d);
    @(negedge clk);
    din_valid = v; frame_sync = s; din = d;
    @(posedge clk);
    model_step(v, s, d);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; din_valid = 1'b0; frame_sync = 1'b0; din = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (ch_data !== '0 || ch_valid !== '0 || frame_done !== 1'b0 ||
        sync_err !== 1'b0 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: data=%h valid=%b done=%b err=%b locked=%b, required all zero",
               ch_data, ch_valid, frame_done, sync_err, locked);
    end
  endtask

  task automatic test_lock_route();
    logic [NUM_CH-1:0] exp_v;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i == 0, 8'hA0 + 8'(i));
      exp_v = '0; exp_v[i] = 1'b1;
      n_checks++;
      if (ch_valid !== exp_v || locked !== 1'b1 || frame_done !== (i == 3) || sync_err !== 1'b0) begin
        n_fail++;
        $display("FAIL lock_route beat %0d: valid=%b locked=%b done=%b err=%b, required valid=%b locked=1 done=%0d err=0",
                 i, ch_valid, locked, frame_done, sync_err, exp_v, (i == 3));
      end
    end
    n_checks++;
    if (ch_data !== 32'hA3A2A1A0) begin
      n_fail++;
      $display("FAIL lock_route data: got %h required a3a2a1a0", ch_data);
    end
    drive(1'b0, 1'b0, 8'h00);
    n_checks++;
    if (ch_valid !== '0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_route idle: valid=%b done=%b required 0", ch_valid, frame_done);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    drive(1'b1, 1'b1, 8'hA0);
    drive(1'b1, 1'b0, 8'hA1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 8'hFF);
      n_checks++;
      if (ch_valid !== '0 || frame_done !== 1'b0 || sync_err !== 1'b0) begin
        n_fail++;
        $display("FAIL gaps idle %0d: valid=%b done=%b err=%b required 0", i, ch_valid, frame_done, sync_err);
      end
    end
    drive(1'b1, 1'b0, 8'hA2);
    n_checks++;
    if (ch_valid !== 4'b0100) begin
      n_fail++;
      $display("FAIL gaps slot2: valid=%b required 0100", ch_valid);
    end
    drive(1'b1, 1'b0, 8'hA3);
    n_checks++;
    if (ch_data !== 32'hA3A2A1A0 || frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL gaps final: data=%h done=%b required a3a2a1a0 done=1", ch_data, frame_done);
    end
  endtask

  task automatic test_misplaced();
    do_reset();
    drive(1'b1, 1'b1, 8'hA0);
    drive(1'b1, 1'b0, 8'hA1);
    drive(1'b1, 1'b1, 8'h55);
    n_checks++;
    if (sync_err !== 1'b1 || ch_valid !== 4'b0001 || ch_data[7:0] !== 8'h55 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL misplaced sync: err=%b valid=%b ch0=%h done=%b required err=1 valid=0001 ch0=55 done=0",
               sync_err, ch_valid, ch_data[7:0], frame_done);
    end
    drive(1'b1, 1'b0, 8'h66);
    n_checks++;
    if (sync_err !== 1'b0 || ch_valid !== 4'b0010 || ch_data[15:8] !== 8'h66 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL misplaced next: err=%b valid=%b ch1=%h done=%b required err=0 valid=0010 ch1=66 done=0",
               sync_err, ch_valid, ch_data[15:8], frame_done);
    end
  endtask

  task automatic test_missing();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, i == 0, 8'hA0 + 8'(i));
    for (int f = 1; f <= 2; f++) begin
      drive(1'b1, 1'b0, 8'(f * 16 + 160));
      n_checks++;
      if (sync_err !== 1'b1 || locked !== 1'b1 || ch_valid !== 4'b0001 || ch_data[7:0] !== 8'(f * 16 + 160)) begin
        n_fail++;
        $display("FAIL missing frame %0d: err=%b locked=%b valid=%b ch0=%h required err=1 locked=1 valid=0001 ch0=%h",
                 f, sync_err, locked, ch_valid, ch_data[7:0], 8'(f * 16 + 160));
      end
      for (int i = 1; i < 4; i++) drive(1'b1, 1'b0, 8'(f * 16 + 160 + i));
    end
    drive(1'b1, 1'b0, 8'hD0);
    n_checks++;
    if (sync_err !== 1'b1 || locked !== 1'b0 || ch_valid !== '0 || ch_data[7:0] !== 8'hC0) begin
      n_fail++;
      $display("FAIL missing drop: err=%b locked=%b valid=%b ch0=%h required err=1 locked=0 valid=0000 ch0=c0",
               sync_err, locked, ch_valid, ch_data[7:0]);
    end
    drive(1'b1, 1'b0, 8'hD1);
    n_checks++;
    if (ch_valid !== '0 || sync_err !== 1'b0 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL missing hunt: valid=%b err=%b locked=%b required 0", ch_valid, sync_err, locked);
    end
    drive(1'b1, 1'b1, 8'hE0);
    n_checks++;
    if (locked !== 1'b1 || ch_valid !== 4'b0001 || ch_data[7:0] !== 8'hE0) begin
      n_fail++;
      $display("FAIL missing relock: locked=%b valid=%b ch0=%h required 1 0001 e0", locked, ch_valid, ch_data[7:0]);
    end
  endtask

  task automatic test_pre_lock();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 8'($urandom));
      n_checks++;
      if (ch_data !== '0 || ch_valid !== '0 || locked !== 1'b0 || sync_err !== 1'b0 || frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL pre_lock beat %0d: data=%h valid=%b locked=%b err=%b done=%b required all zero",
                 i, ch_data, ch_valid, locked, sync_err, frame_done);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 1'b1, 8'h11);
    drive(1'b1, 1'b0, 8'h22);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ch_data !== '0 || ch_valid !== '0 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: data=%h valid=%b locked=%b required all zero", ch_data, ch_valid, locked);
    end
    model_reset();
    @(negedge clk);
    din_valid = 1'b0; frame_sync = 1'b0;
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 8'h99);
    n_checks++;
    if (ch_valid !== '0 || locked !== 1'b0 || ch_data !== '0) begin
      n_fail++;
      $display("FAIL async_reset post: valid=%b locked=%b data=%h required all zero", ch_valid, locked, ch_data);
    end
  endtask

  task automatic test_random();
    int  tx_slot;
    bit  no_sync;
    bit  v, s;
    int  r;
    do_reset();
    tx_slot = 0;
    no_sync = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (c % 40 == 0) no_sync = ($urandom_range(0, 3) == 0);
      v = ($urandom_range(0, 3) != 0);
      s = 1'b0;
      if (v) begin
        s = (tx_slot == 0) && !no_sync;
        r = $urandom_range(0, 23);
        if (r == 0) s = !s;
        tx_slot = (r == 1) ? 0 : (tx_slot + 1) % NUM_CH;
      end else begin
        s = ($urandom_range(0, 1) == 1);
      end
      drive(v, s, 8'($urandom));
      n_checks++;
      if (ch_data !== model_data() || ch_valid !== m_valid || frame_done !== m_done ||
          sync_err !== m_err || locked !== m_locked) begin
        n_fail++;
        $display("FAIL random cycle %0d: data=%h valid=%b done=%b err=%b locked=%b required data=%h valid=%b done=%b err=%b locked=%b",
                 c, ch_data, ch_valid, frame_done, sync_err, locked,
                 model_data(), m_valid, m_done, m_err, m_locked);
      end
    end
  endtask

  initial begin
    rst_n = 1'b1; din = '0; din_valid = 1'b0; frame_sync = 1'b0;
    model_reset();
    test_reset();
    test_lock_route();
    test_gaps();
    test_misplaced();
    test_missing();
    test_pre_lock();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_demux1x4.md
Name: tdm_demux1x4

Overview:
- Time-division demultiplexer, the receive end of the team's 2:1/N:1 multiplexer path.
- Accepts one interleaved sample stream with a frame-sync marker on slot 0.
- Routes each accepted sample to its channel's output register and pulses that channel's valid.
- Tracks frame alignment, flags sync errors, and drops lock after repeated missing sync.

Parameters:
- NUM_CH, 4, number of TDM slots/output channels per frame (2..16).
- DATA_W, 8, sample width in bits.
- MISS_LIMIT, 3, consecutive frames with missing sync before lock is dropped (1..15).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- din  in  DATA_W  interleaved input sample.
- din_valid  in  1  din carries a sample this cycle; no backpressure.
- frame_sync  in  1  qualified by din_valid; marks the current sample as slot 0.
- ch_data  out  NUM_CH*DATA_W  per-channel holding registers; channel k occupies bits [k*DATA_W +: DATA_W].
- ch_valid  out  NUM_CH  one-cycle pulse per channel when its register updates.
- frame_done  out  1  one-cycle pulse when slot NUM_CH-1 is written while LOCKED.
- locked  out  1  high in LOCKED state.
- sync_err  out  1  one-cycle pulse on misplaced or missing sync while LOCKED.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - ch_data=0, ch_valid=0, frame_done=0, sync_err=0, locked=0.
  - state=HUNT, slot=0, miss_cnt=0.
- An accepted beat is din_valid=1 at a rising edge. Cycles with din_valid=0 change nothing except clearing the pulse outputs, so slot holds across gaps.
- Latency: every registered output reflects the accepted beat exactly one cycle later. ch_data[k] holds its value until its next write.
- State HUNT:
  - Beats without frame_sync are discarded; no outputs change.
  - A beat with frame_sync: write din to ch 0, pulse ch_valid[0], set slot=1, miss_cnt=0, go to LOCKED (locked=1 the next cycle).
- State LOCKED, on each accepted beat:
  - frame_sync=1 and slot==0: normal. Write ch 0, slot=1, miss_cnt=0.
  - frame_sync=1 and slot!=0: misalignment.
    - Pulse sync_err.
    - Treat the beat as slot 0: write ch 0, slot=1, miss_cnt=0.
    - Remaining slots of the broken frame are abandoned; no frame_done for it.
  - frame_sync=0 and slot==0: missing sync.
    - Pulse sync_err, miss_cnt+1.
    - If the new miss_cnt reaches MISS_LIMIT: go to HUNT, locked=0, discard the beat, slot=0.
    - Otherwise (flywheel): write ch 0 and advance slot.
  - frame_sync=0 and slot!=0: write ch[slot]. Pulse frame_done if slot==NUM_CH-1. Next slot is slot+1, wrapping to 0 after NUM_CH-1.
- Slot counter width is clog2(NUM_CH). Wrap is explicit compare-to-NUM_CH-1, so non-power-of-2 NUM_CH is legal.
- At most one ch_valid bit is high in any cycle. frame_done coincides with ch_valid[NUM_CH-1].
- Reset mid-frame: everything clears immediately; after release the block hunts for a fresh sync.
- frame_sync with din_valid=0 is ignored in all states.

Decomposition:
- Shared package tdm_pkg:
  - state encoding (HUNT=1'b0, LOCKED=1'b1).
  - default NUM_CH/DATA_W constants.
  - a clog2 function, reused by the tdm mux transmit side.
- One natural sub-module, tdm_slot_ctr:
  - modulo-NUM_CH counter with enable, load-to-1, and clear.
  - outputs slot and last_slot flag.
  - instantiated here and in the transmit-side mux.
- FSM, miss counter and channel registers stay in tdm_demux1x4.

Test Plan:
- Lock and route: reset, then beats 0xA0(sync),0xA1,0xA2,0xA3 -> locked=1 after first beat. ch_data = {A3,A2,A1,A0}. ch_valid pulses 1,2,4,8 on consecutive cycles. frame_done with ch_valid=8.
- Gaps: same frame with din_valid low for 3 cycles between 0xA1 and 0xA2 -> slot holds, identical final ch_data, no spurious pulses during the gap.
- Misplaced sync: locked, sync arrives on slot 2 with 0x55 -> sync_err pulse, ch_data[0]=0x55, next beat lands in ch 1, no frame_done for the broken frame.
- Missing sync, MISS_LIMIT=3: three consecutive frames without sync -> sync_err on each slot-0 beat. First two frames still routed (flywheel). Third slot-0 beat discarded, locked=0. A later sync relocks.
- Pre-lock garbage: 5 beats with no sync after reset -> all outputs stay 0, locked=0.
- Async reset mid-frame: assert rst_n=0 between clock edges after slot 1 -> all outputs 0 immediately. The first post-reset beat without sync is ignored.
